// File: rtl/flash_pkg.sv
// Shared constants for the SPI NOR flash sequencer: opcodes, request encodings,
// one-hot FSM states and the latched request record.
package flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_BE   = 8'hC7;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;

    // Write-in-progress bit of the flash status register
    localparam logic [7:0] SR_WIP  = 8'h01;

    localparam logic [1:0] REQ_SE  = 2'b00;
    localparam logic [1:0] REQ_BE  = 2'b01;
    localparam logic [1:0] REQ_PP  = 2'b10;
    localparam logic [1:0] REQ_INV = 2'b11;

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_WREN = 6'b000010,
        S_GAP1 = 6'b000100,
        S_CMD  = 6'b001000,
        S_GAP2 = 6'b010000,
        S_POLL = 6'b100000
    } state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [23:0] addr;
        logic [7:0]  data;
    } flash_req_t;

    function automatic logic [7:0] cmd_opcode(input logic [1:0] op);
        case (op)
            REQ_BE:  return OP_BE;
            REQ_PP:  return OP_PP;
            default: return OP_SE;
        endcase
    endfunction

    // Index of the last byte in the command frame
    function automatic logic [2:0] cmd_last(input logic [1:0] op);
        case (op)
            REQ_BE:  return 3'd0;
            REQ_PP:  return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// SPI mode-0 byte shifter: 4 sys_clk per bit, mosi MSB first from phase 0,
// sck high in phases 2-3, miso sampled at phase 3; byte_end on the last phase.
module spi_byte_shift (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       active,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       byte_end,
    output logic [7:0] rx_byte
);

    logic [1:0] cnt_sck;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_sck <= 2'd0;
            bit_cnt <= 3'd0;
            rx_sh   <= 7'd0;
        end else if (!active) begin
            cnt_sck <= 2'd0;
            bit_cnt <= 3'd0;
        end else begin
            cnt_sck <= cnt_sck + 2'd1;
            if (cnt_sck == 2'd3) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= {rx_sh[5:0], miso};
            end
        end
    end

    assign sck      = active & cnt_sck[1];
    assign mosi     = active & tx_byte[3'd7 - bit_cnt];
    assign byte_end = active && (cnt_sck == 2'd3) && (bit_cnt == 3'd7);
    // Includes the bit being sampled now, so the full byte is valid with byte_end
    assign rx_byte  = {rx_sh, miso};

endmodule

// File: rtl/flash_op_ctrl.sv
// SPI NOR flash operation sequencer: WREN, gap, SE/BE/PP command, gap, RDSR poll.
// Define FLASH_TIMEOUT_EN to bound the poll to POLL_MAX status bytes with err.
module flash_op_ctrl
    import flash_pkg::*;
#(
    parameter int CS_GAP = 32
`ifdef FLASH_TIMEOUT_EN
    , parameter logic [23:0] POLL_MAX = 24'd8_000_000
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int GAP_W = $clog2(CS_GAP) + 1;

    state_t           state, state_nxt;
    flash_req_t       req_q;
    logic [2:0]       byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             done_nxt, err_nxt;
    logic             frame_act, byte_end, accept, wip;
    logic [7:0]       tx_byte, rx_byte;

    // A request landing on the done cycle is still treated as arriving while busy
    assign accept    = (state == S_IDLE) && !done && req_valid && (req_op != REQ_INV);
    assign frame_act = (state == S_WREN) || (state == S_CMD) || (state == S_POLL);
    assign cs_n      = ~frame_act;
    assign busy      = (state != S_IDLE) || done;
    assign wip       = |(rx_byte & SR_WIP);

    spi_byte_shift u_shift (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .active    (frame_act),
        .tx_byte   (tx_byte),
        .miso      (miso),
        .sck       (sck),
        .mosi      (mosi),
        .byte_end  (byte_end),
        .rx_byte   (rx_byte)
    );

`ifdef FLASH_TIMEOUT_EN
    logic [23:0] poll_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            poll_cnt <= 24'd0;
            err      <= 1'b0;
        end else begin
            err <= err_nxt;
            if (state != S_POLL)
                poll_cnt <= 24'd0;
            else if (byte_end && byte_cnt != 3'd0)
                poll_cnt <= poll_cnt + 24'd1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        tx_byte   = 8'h00;
        case (state)
            S_IDLE: if (accept) state_nxt = S_WREN;
            S_WREN: begin
                tx_byte = OP_WREN;
                if (byte_end) state_nxt = S_GAP1;
            end
            S_GAP1: if (gap_cnt == GAP_W'(CS_GAP - 1)) state_nxt = S_CMD;
            S_CMD: begin
                case (byte_cnt)
                    3'd0:    tx_byte = cmd_opcode(req_q.op);
                    3'd1:    tx_byte = req_q.addr[23:16];
                    3'd2:    tx_byte = req_q.addr[15:8];
                    3'd3:    tx_byte = req_q.addr[7:0];
                    default: tx_byte = req_q.data;
                endcase
                if (byte_end && byte_cnt == cmd_last(req_q.op)) state_nxt = S_GAP2;
            end
            S_GAP2: if (gap_cnt == GAP_W'(CS_GAP - 1)) state_nxt = S_POLL;
            S_POLL: begin
                // First byte is the RDSR opcode; every later byte is a status readback
                tx_byte = (byte_cnt == 3'd0) ? OP_RDSR : 8'h00;
                if (byte_end && byte_cnt != 3'd0) begin
                    if (!wip) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
`ifdef FLASH_TIMEOUT_EN
                    else if (poll_cnt == POLL_MAX - 24'd1) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            req_q    <= '0;
            byte_cnt <= 3'd0;
            gap_cnt  <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (accept) begin
                req_q.op   <= req_op;
                req_q.addr <= req_addr;
                req_q.data <= req_data;
            end
            // Byte index saturates so a long status poll cannot wrap back to the opcode
            if (state_nxt != state)
                byte_cnt <= 3'd0;
            else if (byte_end && byte_cnt != 3'd7)
                byte_cnt <= byte_cnt + 3'd1;
            if ((state == S_GAP1 || state == S_GAP2) && state_nxt == state)
                gap_cnt <= gap_cnt + GAP_W'(1);
            else
                gap_cnt <= '0;
        end
    end

endmodule

// File: doc/flash_op_ctrl.md
Name: flash_op_ctrl

Overview:
- Command sequencer for the board's SPI NOR flash (M25P16-class, SPI mode 0).
- Takes one operation request (sector erase, bulk erase or single-byte page program) and issues the full flash sequence on sck/cs_n/mosi:
  - WREN frame,
  - chip-select gap,
  - command frame,
  - gap,
  - RDSR status polling until WIP clears.
- Sits between key/UART-driven test logic and the flash pins, replacing the per-operation hard-wired controllers.

Parameters:
- CS_GAP, 32, sys_clk cycles cs_n is held high between frames (≥100 ns at 50 MHz).
- POLL_MAX, 24'd8_000_000, maximum RDSR status bytes before timeout (used only with FLASH_TIMEOUT_EN).

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  operation request, sampled only in IDLE
- req_op  in  2  00 = SE (0xD8), 01 = BE (0xC7), 10 = PP (0x02), 11 = invalid
- req_addr  in  24  flash byte address (SE/PP); ignored for BE
- req_data  in  8  program byte (PP only)
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse when the operation completes
- err  out  1  one-cycle pulse with done on timeout; constant 0 without FLASH_TIMEOUT_EN
- sck  out  1  SPI clock, sys_clk/4
- cs_n  out  1  flash chip select, active low
- mosi  out  1  serial data to flash
- miso  in  1  serial data from flash

Behaviour:
- Reset: state = IDLE; busy = 0, done = 0, err = 0, sck = 0, cs_n = 1, mosi = 0; all counters 0.

Acceptance:
- In IDLE, req_valid = 1 with req_op != 11 latches op/addr/data; busy = 1 on the next cycle.
- req_op = 11 is dropped; busy stays 0.
- req_valid while busy is ignored.

States: IDLE → WREN → GAP1 → CMD → GAP2 → POLL → IDLE.

Bit timing:
- Each bit is 4 sys_clk cycles; phase counter cnt_sck runs 0..3.
- mosi is updated at phase 0, MSB first.
- sck = 0 in phases 0–1 and 1 in phases 2–3.
- miso is sampled at phase 3.
- One byte is 32 cycles.

Frames:
- cs_n falls on the first cycle of a frame state and rises on the cycle after the last byte's phase 3.
- sck = 0 whenever cs_n changes.
- mosi = 0 whenever cs_n = 1.

WREN:
- 1-byte frame, 0x06.
- Then GAP1: cs_n high for CS_GAP cycles.

CMD frame length by op:
- SE: 4 bytes (0xD8, addr[23:16], addr[15:8], addr[7:0]).
- BE: 1 byte (0xC7).
- PP: 5 bytes (0x02, addr bytes, data).
- Then GAP2: CS_GAP cycles high.

POLL:
- cs_n goes low; 0x05 is sent, then status bytes are clocked in continuously with cs_n held low and mosi = 0.
- After each full status byte, status[0] (WIP) = 0 ends the frame: cs_n rises, state returns to IDLE, and done pulses in that same cycle.
- busy falls on the following cycle.

Mid-operation:
- Reset at any point immediately forces the reset values; cs_n = 1 aborts the flash command.
- No request queueing.

Optional Feature:
- FLASH_TIMEOUT_EN defined:
  - A 24-bit counter counts status bytes in POLL.
  - When it reaches POLL_MAX with WIP still 1, the frame is ended, err and done pulse together, and the block returns to IDLE.
- FLASH_TIMEOUT_EN not defined:
  - No counter; POLL waits indefinitely.
  - err is tied to 0.

Decomposition:
- Shared package flash_pkg:
  - opcode constants: OP_WREN 0x06, OP_SE 0xD8, OP_BE 0xC7, OP_PP 0x02, OP_RDSR 0x05;
  - req_op encodings;
  - state one-hot constants.
- One natural sub-module, spi_byte_shift:
  - shifts one byte out and in over 32 cycles;
  - generates sck;
  - raises byte_end.
- flash_op_ctrl counts bytes and owns cs_n.

Test Plan:
- SE at addr 0x12_3456, flash model returns WIP = 1 for 3 status bytes then 0:
  - mosi frames 06 | D8 12 34 56 | 05 + 4 status bytes;
  - each gap has cs_n high exactly 32 cycles;
  - done pulses once; busy deasserts the next cycle.
- PP at addr 0x00_0100 with data 0xA5: CMD frame is 02 00 01 00 A5, 160 cycles with cs_n low.
- BE with WIP = 0 on the first status byte: CMD frame is a single C7 byte; POLL frame lasts 64 cycles.
- Edge cases:
  - req_op = 11 is ignored: busy stays 0.
  - A second req_valid during CMD is ignored, with no second sequence.
  - sck frequency = sys_clk/4.
- Reset asserted mid-CMD (byte 2): cs_n = 1, sck = 0, busy = 0 immediately; a new request afterwards runs a clean sequence.
- With FLASH_TIMEOUT_EN and POLL_MAX = 5, WIP held at 1: after 5 status bytes, cs_n rises and err + done pulse in the same cycle.
